// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words and writes them out.
// Optional checksum trailer verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int MEM_SIZE = 256,
    parameter int CNT_W    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] num_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd5;
    logic [31:0]      sum;
`endif

    logic [2:0]       state;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] nwords;
    logic [1:0]       byte_cnt;
    logic [23:0]      asm_lo;
    logic             accept;
    logic             idle_like;
    logic [31:0]      full_word;

    always_comb begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_ready = (state == S_RECV) || (state == S_CHK);
        // The checksum trailer is still part of the load, so it counts as busy.
        busy       = (state == S_RECV) || (state == S_WRITE) || (state == S_CHK);
`else
        byte_ready = (state == S_RECV);
        busy       = (state == S_RECV) || (state == S_WRITE);
`endif
        mem_we    = (state == S_WRITE);
        done      = (state == S_DONE);
        error     = (state == S_ERR);
        cpu_hold  = (state != S_DONE);
        accept    = byte_valid && byte_ready;
        idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
        full_word = {byte_data, asm_lo};
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            word_idx  <= '0;
            nwords    <= '0;
            byte_cnt  <= '0;
            asm_lo    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            // Lower three lanes are collected here; lane 3 completes the word directly.
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    asm_lo[7:0]   <= byte_data;
                    2'd1:    asm_lo[15:8]  <= byte_data;
                    2'd2:    asm_lo[23:16] <= byte_data;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        word_idx <= '0;
                        byte_cnt <= '0;
                        nwords   <= num_words[CNT_W-1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum      <= '0;
`endif
                        if (num_words > 32'(MEM_SIZE))
                            state <= S_ERR;
                        else if (num_words == 32'd0)
                            state <= S_DONE;
                        else
                            state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (accept && byte_cnt == 2'd3) begin
                        mem_wdata <= full_word;
                        mem_addr  <= {{(30-CNT_W){1'b0}}, word_idx, 2'b00};
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum      <= sum + mem_wdata;
                    if (word_idx + CNT_W'(1) == nwords)
                        state <= S_CHK;
                    else
                        state <= S_RECV;
`else
                    if (word_idx + CNT_W'(1) == nwords)
                        state <= S_DONE;
                    else
                        state <= S_RECV;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept && byte_cnt == 2'd3)
                        state <= (full_word == sum) ? S_DONE : S_ERR;
                end
`endif
                default: state <= S_IDLE;
            endcase

            // idle_like gates start so a pulse during a load never restarts it.
            if (!idle_like && start) begin
                state <= state;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized loads scored against a word-level reference model.
// Define IMEM_LOADER_CHECKSUM_EN for both files to exercise the checksum trailer.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, mem_we, busy, done, error, cpu_hold;
    logic [31:0] mem_addr, mem_wdata;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int DONE_LAT = 5;
`else
    localparam int DONE_LAT = 1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    int          done_cyc = -1;
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        if (mem_we) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
            obs_cyc.push_back(cyc);
        end
        if (done && !prev_done) done_cyc = cyc;
        prev_done = done;
    end

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        done_cyc = -1;
    endtask

    // Byte stream for a list of words, optionally followed by a (possibly corrupted) checksum.
    task automatic build_stream(input logic [31:0] w[$], input bit chk_ok, output logic [7:0] b[$]);
        logic [31:0] s;
        b.delete();
        s = 32'd0;
        foreach (w[i]) begin
            s = s + w[i];
            for (int j = 0; j < 4; j++) b.push_back(8'((w[i] >> (8 * j)) & 32'hFF));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!chk_ok) s = s + 32'd1;
        for (int j = 0; j < 4; j++) b.push_back(8'((s >> (8 * j)) & 32'hFF));
`else
        if (!chk_ok) s = 32'd0;
`endif
    endtask

    task automatic do_start(input logic [31:0] n, output int t0);
        start = 1'b1; num_words = n;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    // Presents bytes in order; g[k] idle cycles precede byte k. Bounded wait on byte_ready.
    task automatic send_bytes(input logic [7:0] b[$], input int g[$], output bit ok);
        int budget;
        ok = 1'b1;
        foreach (b[k]) begin
            if (k < g.size() && g[k] > 0) begin
                byte_valid = 1'b0;
                repeat (g[k]) @(negedge clk);
            end
            byte_valid = 1'b1; byte_data = b[k];
            budget = 0;
            while (!byte_ready && budget < 50) begin @(negedge clk); budget++; end
            if (!byte_ready) begin ok = 1'b0; break; end
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        int budget = 0;
        while (!done && !error && budget < 30) begin @(negedge clk); budget++; end
        ok = done || error;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (cpu_hold !== 1'b1)   begin n_bad++; $display("FAIL reset_cpu_hold got=%b want=1", cpu_hold); end
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (error !== 1'b0)      begin n_bad++; $display("FAIL reset_error got=%b want=0", error); end
        n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", byte_ready); end
        n_cmp++; if (mem_we !== 1'b0)     begin n_bad++; $display("FAIL reset_we got=%b want=0", mem_we); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0)
            begin n_bad++; $display("FAIL reset_mem got=%h/%h want=0/0", mem_addr, mem_wdata); end
    endtask

    // Fixed two-word program, optional gap before byte 2; checks data, addresses and timing.
    task automatic test_basic(input int gap, input int want_lat, input string nm);
        logic [31:0] w[$];
        logic [7:0]  b[$];
        int          g[$];
        int          t0;
        bit          ok;
        w = '{32'h0000_0013, 32'h0050_00B3};
        build_stream(w, 1'b1, b);
        g = '{0, 0, gap};
        clear_obs();
        do_start(32'd2, t0);
        send_bytes(b, g, ok);
        if (ok) wait_end(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_timeout got=stuck want=finish", nm); end
        n_cmp++; if (obs_addr.size() != 2) begin n_bad++; $display("FAIL %s_count got=%0d want=2", nm, obs_addr.size()); end
        foreach (obs_addr[i]) if (i < 2) begin
            n_cmp++; if (obs_addr[i] !== 32'(4 * i) || obs_data[i] !== w[i])
                begin n_bad++; $display("FAIL %s_w%0d got=%h:%h want=%h:%h", nm, i, obs_addr[i], obs_data[i], 4 * i, w[i]); end
        end
        if (obs_cyc.size() == 2) begin
            n_cmp++; if (obs_cyc[0] - t0 != want_lat)
                begin n_bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, obs_cyc[0] - t0, want_lat); end
            n_cmp++; if (done_cyc != obs_cyc[1] + DONE_LAT)
                begin n_bad++; $display("FAIL %s_done_time got=%0d want=%0d", nm, done_cyc, obs_cyc[1] + DONE_LAT); end
        end
        n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0)
            begin n_bad++; $display("FAIL %s_final got=done%b hold%b want=done1 hold0", nm, done, cpu_hold); end
    endtask

    task automatic test_error_zero();
        int t0;
        clear_obs();
        do_start(32'd257, t0);
        n_cmp++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0)
            begin n_bad++; $display("FAIL oversize got=err%b hold%b done%b want=err1 hold1 done0", error, cpu_hold, done); end
        repeat (4) @(negedge clk);
        n_cmp++; if (obs_addr.size() != 0) begin n_bad++; $display("FAIL oversize_writes got=%0d want=0", obs_addr.size()); end
        n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL err_ready got=%b want=0", byte_ready); end
        do_start(32'd256 + 32'h1000_0000, t0);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL oversize_hi got=%b want=1", error); end
        do_start(32'd0, t0);
        n_cmp++; if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0)
            begin n_bad++; $display("FAIL zero_words got=done%b err%b hold%b want=done1 err0 hold0", done, error, cpu_hold); end
        do_start(32'd0, t0);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_again got=%b want=1", done); end
    endtask

    task automatic test_reset_midload();
        logic [31:0] w[$];
        logic [7:0]  b[$];
        logic [7:0]  part[$];
        int          g[$];
        int          t0;
        bit          ok;
        w = '{$urandom(), $urandom()};
        build_stream(w, 1'b1, b);
        part = b[0:5];
        clear_obs();
        do_start(32'd2, t0);
        send_bytes(part, g, ok);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (obs_addr.size() != 1) begin n_bad++; $display("FAIL midreset_count got=%0d want=1", obs_addr.size()); end
        n_cmp++; if (obs_addr.size() > 0 && (obs_addr[0] !== 32'd0 || obs_data[0] !== w[0]))
            begin n_bad++; $display("FAIL midreset_w0 got=%h want=%h", obs_data[0], w[0]); end
        n_cmp++; if (busy !== 1'b0 || byte_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0)
            begin n_bad++; $display("FAIL midreset_idle got=busy%b rdy%b hold%b done%b", busy, byte_ready, cpu_hold, done); end
        w = '{$urandom()};
        build_stream(w, 1'b1, b);
        clear_obs();
        do_start(32'd1, t0);
        send_bytes(b, g, ok);
        if (ok) wait_end(ok);
        n_cmp++; if (!ok || obs_addr.size() != 1 || done !== 1'b1)
            begin n_bad++; $display("FAIL reload got=ok%b n%0d done%b want=ok1 n1 done1", ok, obs_addr.size(), done); end
        n_cmp++; if (obs_addr.size() > 0 && (obs_addr[0] !== 32'd0 || obs_data[0] !== w[0]))
            begin n_bad++; $display("FAIL reload_w0 got=%h:%h want=0:%h", obs_addr[0], obs_data[0], w[0]); end
    endtask

    // A start pulse in the middle of a load must be ignored.
    task automatic test_busy_start();
        logic [31:0] w[$];
        logic [7:0]  b[$];
        int          g[$];
        int          t0;
        bit          ok;
        w = '{$urandom(), $urandom(), $urandom()};
        build_stream(w, 1'b1, b);
        clear_obs();
        do_start(32'd3, t0);
        send_bytes(b[0:4], g, ok);
        start = 1'b1; num_words = 32'd0;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0)
            begin n_bad++; $display("FAIL busy_start_state got=busy%b done%b want=busy1 done0", busy, done); end
        send_bytes(b[5:$], g, ok);
        if (ok) wait_end(ok);
        n_cmp++; if (!ok || obs_addr.size() != 3 || done !== 1'b1)
            begin n_bad++; $display("FAIL busy_start got=ok%b n%0d done%b want=ok1 n3 done1", ok, obs_addr.size(), done); end
        foreach (obs_addr[i]) if (i < 3) begin
            n_cmp++; if (obs_addr[i] !== 32'(4 * i) || obs_data[i] !== w[i])
                begin n_bad++; $display("FAIL busy_start_w%0d got=%h:%h want=%h:%h", i, obs_addr[i], obs_data[i], 4 * i, w[i]); end
        end
    endtask

    task automatic test_random(input int iters, input int max_n, input int max_gap, input string nm);
        logic [31:0] w[$];
        logic [7:0]  b[$];
        int          g[$];
        int          t0, n;
        bit          ok, chk_ok;
        for (int it = 0; it < iters; it++) begin
            n = (max_n > 8) ? max_n : $urandom_range(1, max_n);
            w.delete(); g.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom());
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_ok = ($urandom_range(0, 3) != 0);
`else
            chk_ok = 1'b1;
`endif
            build_stream(w, chk_ok, b);
            foreach (b[k]) g.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, max_gap) : 0);
            clear_obs();
            do_start(32'(n), t0);
            send_bytes(b, g, ok);
            if (ok) wait_end(ok);
            n_cmp++; if (!ok || obs_addr.size() != n)
                begin n_bad++; $display("FAIL %s%0d_count got=ok%b n%0d want=ok1 n%0d", nm, it, ok, obs_addr.size(), n); end
            foreach (obs_addr[i]) if (i < n) begin
                n_cmp++; if (obs_addr[i] !== 32'(4 * i) || obs_data[i] !== w[i])
                    begin n_bad++; $display("FAIL %s%0d_w%0d got=%h:%h want=%h:%h", nm, it, i, obs_addr[i], obs_data[i], 4 * i, w[i]); end
            end
            n_cmp++; if (done !== chk_ok || error !== !chk_ok || cpu_hold !== !chk_ok)
                begin n_bad++; $display("FAIL %s%0d_end got=done%b err%b hold%b want_done=%b", nm, it, done, error, cpu_hold, chk_ok); end
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum(input logic [31:0] sum_word, input bit want_ok);
        logic [7:0] b[$];
        int         g[$];
        int         t0;
        bit         ok;
        b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00};
        for (int j = 0; j < 4; j++) b.push_back(8'((sum_word >> (8 * j)) & 32'hFF));
        clear_obs();
        do_start(32'd2, t0);
        send_bytes(b, g, ok);
        if (ok) wait_end(ok);
        n_cmp++; if (!ok || obs_addr.size() != 2)
            begin n_bad++; $display("FAIL chk_%h_writes got=ok%b n%0d want=ok1 n2", sum_word, ok, obs_addr.size()); end
        n_cmp++; if (done !== want_ok || error !== !want_ok)
            begin n_bad++; $display("FAIL chk_%h_result got=done%b err%b want_done=%b", sum_word, done, error, want_ok); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic(0, 4, "basic");
        test_basic(3, 7, "stall");
        test_error_zero();
        test_reset_midload();
        test_busy_start();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum(32'h0050_00C6, 1'b1);
        test_checksum(32'h0050_00C7, 1'b0);
`endif
        test_random(12, 6, 3, "rand");
        test_random(1, 256, 0, "full");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that fills the instruction memory before the single-cycle core runs.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one write per word on a word-aligned byte-address write port. The read side indexes memory with address >> 2.
- Holds the core in reset until the load completes.

Parameters:
- MEM_SIZE, 256, instruction memory depth in 32-bit words; upper bound on num_words.
- CNT_W, 9, width of the internal word counter; must satisfy 2^CNT_W > MEM_SIZE.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERR.
- num_words  in  32  number of words to load; sampled on the start cycle.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts the byte this cycle; transfer occurs when byte_valid and byte_ready are both 1.
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  out  32  byte address = word_index * 4; bits [1:0] are always 0.
- mem_wdata  out  32  assembled word.
- busy  out  1  load in progress (RECV or WRITE).
- done  out  1  load completed successfully.
- error  out  1  load rejected or failed.
- cpu_hold  out  1  holds the core in reset; 1 unless in DONE.

Behaviour:
- Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1, internal counters=0.
- States: IDLE, RECV, WRITE, DONE, ERR.
- IDLE, DONE or ERR, on start:
  - Latch num_words; clear done and error; clear word_idx and byte_cnt.
  - num_words > MEM_SIZE -> ERR.
  - num_words == 0 -> DONE.
  - Otherwise -> RECV.
- RECV:
  - byte_ready=1.
  - Each accepted byte goes to lane byte_cnt: byte 0 -> [7:0], byte 3 -> [31:24].
  - byte_cnt increments on each accepted byte.
  - On acceptance of byte 3 -> WRITE, and byte_cnt returns to 0.
  - byte_valid=0 stalls indefinitely with no timeout.
- WRITE, exactly one cycle:
  - byte_ready=0, mem_we=1, mem_addr=word_idx<<2, mem_wdata=assembled word.
  - word_idx increments.
  - If word_idx+1 == num_words -> DONE, else -> RECV.
  - Throughput: 5 cycles per word minimum (4 accepts plus 1 write bubble).
- mem_addr and mem_wdata are registered and hold their last value when mem_we=0.
- DONE: done=1, cpu_hold=0, byte_ready=0; holds until reset or start.
- ERR: error=1, cpu_hold=1, byte_ready=0; holds until reset or start.
- start while busy is ignored; no restart occurs.
- Reset mid-load returns to IDLE on the same edge:
  - A partially assembled word is discarded and never written.
  - Words already written remain in memory.
- No wrap-around: word_idx never exceeds MEM_SIZE-1 because oversize loads are rejected at start.
- A start in DONE drops done and raises cpu_hold on the next cycle.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit wrapping sum of all written words is kept, cleared on start.
  - After the last WRITE, state CHK receives 4 more bytes (little-endian) as the expected sum. These bytes are not written to memory.
  - Match -> DONE; mismatch -> ERR.
  - num_words == 0 still goes directly to DONE with no checksum word.
- Undefined:
  - No CHK state and no checksum logic; the last WRITE goes directly to DONE.

Test Plan:
- Reset, then idle 5 cycles -> cpu_hold=1, done=0, error=0, byte_ready=0, mem_we=0.
- start with num_words=2; bytes 13,00,00,00,B3,00,50,00 with no gaps:
  - mem_we pulses at addr 0 with data 0x00000013.
  - mem_we pulses at addr 4 with data 0x005000B3.
  - done=1 and cpu_hold=0 one cycle after the second write.
- Same load with byte_valid low for 3 cycles between bytes 1 and 2 -> identical writes; first write is 3 cycles later.
- start with num_words=257 -> ERR next cycle, error=1, no mem_we. Then start with num_words=0 -> DONE, error=0, done=1.
- Reset asserted after 6 of 8 bytes of a num_words=2 load:
  - Only the addr-0 write occurs; state=IDLE.
  - A new start with num_words=1 writes addr 0 correctly.
- With IMEM_LOADER_CHECKSUM_EN, num_words=2 with the words above:
  - Checksum 0x005000C6 -> DONE.
  - Checksum 0x005000C7 -> ERR with both data writes still performed.
